usb_tx_sequencer: RTL

//  Byte-level USB TX packet sequencer, directly downstream of protocol_controller.

---
 rtl/usb_pkg.sv | 39 +++
 rtl/usb_crc16.sv | 32 +++
 rtl/usb_tx_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared constants and types for the USB TX path: command codes, PID/SYNC bytes,
// CRC16 parameters and the sequencer state enum.
package usb_pkg;

    localparam logic [1:0] TxIdle = 2'b00;
    localparam logic [1:0] TxData = 2'b01;
    localparam logic [1:0] TxAck  = 2'b10;
    localparam logic [1:0] TxNak  = 2'b11;

    localparam logic [7:0] SyncByte = 8'h80;
    localparam logic [7:0] PidData0 = 8'hC3;
    localparam logic [7:0] PidData1 = 8'h4B;
    localparam logic [7:0] PidAck   = 8'hD2;
    localparam logic [7:0] PidNak   = 8'h5A;

    localparam logic [15:0] Crc16Poly = 16'hA001;
    localparam logic [15:0] Crc16Init = 16'hFFFF;

    typedef enum logic [3:0] {
        StIdle,
        StSync,
        StPid,
        StData,
        StCrcLo,
        StCrcHi,
        StEop,
        StWaitEop,
        StDone
    } seq_state_e;

    function automatic logic [7:0] pid_byte(input logic [1:0] cmd, input logic toggle);
        case (cmd)
            TxAck:   return PidAck;
            TxNak:   return PidNak;
            default: return toggle ? PidData1 : PidData0;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 (reflected poly 0xA001, LSB first); clear has priority over enable.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc_out ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ Crc16Poly) : (crc_next >> 1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_out <= Crc16Init;
        end else if (clear) begin
            crc_out <= Crc16Init;
        end else if (enable) begin
            crc_out <= crc_next;
        end
    end

endmodule

// File: rtl/usb_tx_sequencer.sv
// Byte-level USB TX packet sequencer: SYNC, PID, payload, CRC16, EOP, then tx_done.
// Define USB_TX_DATA_TOGGLE_EN to alternate DATA0/DATA1 PIDs between DATA packets.
module usb_tx_sequencer
    import usb_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    input  logic       toggle_reset,
    output logic       get_tx_packet_data,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    input  logic       tx_byte_ready,
    output logic       tx_eop,
    input  logic       eop_done,
    output logic       tx_done
);

    localparam logic [6:0] MaxCount = 7'(MAX_BYTES);

    seq_state_e  state;
    logic [1:0]  cmd;
    logic [6:0]  count;
    logic [15:0] crc;
    logic        toggle;
    logic        handshake;
    logic        crc_clear;

    assign handshake          = tx_byte_valid & tx_byte_ready;
    assign get_tx_packet_data = (state == StData) & handshake;
    assign crc_clear          = (state == StPid) & handshake;

    usb_crc16 u_crc (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (crc_clear),
        .enable  (get_tx_packet_data),
        .data_in (tx_byte),
        .crc_out (crc)
    );

`ifdef USB_TX_DATA_TOGGLE_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            toggle <= 1'b0;
        end else if (toggle_reset) begin
            toggle <= 1'b0;
        end else if (state == StDone && cmd == TxData) begin
            toggle <= ~toggle;
        end
    end
`else
    logic unused_toggle_reset;
    assign unused_toggle_reset = toggle_reset;
    assign toggle              = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= StIdle;
            cmd           <= TxIdle;
            count         <= '0;
            tx_byte       <= '0;
            tx_byte_valid <= 1'b0;
            tx_eop        <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (tx_packet != TxIdle) begin
                        cmd           <= tx_packet;
                        tx_byte       <= SyncByte;
                        tx_byte_valid <= 1'b1;
                        state         <= StSync;
                    end
                end
                StSync: begin
                    if (handshake) begin
                        tx_byte <= pid_byte(cmd, toggle);
                        state   <= StPid;
                    end
                end
                StPid: begin
                    if (handshake) begin
                        tx_byte_valid <= 1'b0;
                        count         <= '0;
                        if (cmd == TxData) begin
                            state <= StData;
                        end else begin
                            tx_eop <= 1'b1;
                            state  <= StEop;
                        end
                    end
                end
                // Valid low is a decision cycle: the buffer has settled after the last pop.
                StData: begin
                    if (!tx_byte_valid) begin
                        tx_byte_valid <= 1'b1;
                        if (buffer_occupancy == '0 || count == MaxCount) begin
                            tx_byte <= ~crc[7:0];
                            state   <= StCrcLo;
                        end else begin
                            tx_byte <= tx_packet_data;
                        end
                    end else if (tx_byte_ready) begin
                        tx_byte_valid <= 1'b0;
                        count         <= count + 7'd1;
                    end
                end
                StCrcLo: begin
                    if (handshake) begin
                        tx_byte <= ~crc[15:8];
                        state   <= StCrcHi;
                    end
                end
                StCrcHi: begin
                    if (handshake) begin
                        tx_byte_valid <= 1'b0;
                        tx_eop        <= 1'b1;
                        state         <= StEop;
                    end
                end
                StEop: begin
                    tx_eop <= 1'b0;
                    state  <= StWaitEop;
                end
                StWaitEop: begin
                    if (eop_done) begin
                        tx_done <= 1'b1;
                        state   <= StDone;
                    end
                end
                StDone: begin
                    tx_done <= 1'b0;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
